rename_regfile: RTL and testbench

- Parametrised architectural register file with per-register rename status (busy bit + ROB tag) for the Tomasulo/ROB core.
- Sits between decoder and ROB: the decoder reads NUM_RD source operands and renames one destination per cycle; the ROB commits one result per cycle and can flush all rename state on misbranch.
- Additions over the previous register file:
  - configurable register count, data width, tag width and read-port count;
  - explicit commit valid;
  - optional same-cycle commit bypass on reads;
  - registered busy-register counter.

---
 rtl/rename_regfile_if.sv | 37 +++
 rtl/rename_regfile.sv | 88 ++++++++
 tb/tb_rename_regfile.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rename_regfile_if.sv
// Decoder / ROB facing bundle of the rename register file: read ports, rename,
// commit, flush and the busy-register count.
interface rename_regfile_if #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int ROB_TAG_W = 4,
  parameter int NUM_RD    = 2
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic [NUM_RD*IDX_W-1:0]     in_decode_reg_idx;
  logic [NUM_RD*DATA_W-1:0]    out_decode_value;
  logic [NUM_RD*ROB_TAG_W-1:0] out_decode_rob_tag;
  logic [NUM_RD-1:0]           out_decode_busy;
  logic                        in_rename_ce;
  logic [IDX_W-1:0]            in_rename_reg;
  logic [ROB_TAG_W-1:0]        in_rename_rob;
  logic                        in_commit_ce;
  logic [IDX_W-1:0]            in_commit_reg;
  logic [ROB_TAG_W-1:0]        in_commit_rob;
  logic [DATA_W-1:0]           in_commit_value;
  logic                        in_misbranch;
  logic [CNT_W-1:0]            out_busy_cnt;

  modport master (
    output in_decode_reg_idx, in_rename_ce, in_rename_reg, in_rename_rob,
           in_commit_ce, in_commit_reg, in_commit_rob, in_commit_value, in_misbranch,
    input  out_decode_value, out_decode_rob_tag, out_decode_busy, out_busy_cnt
  );

  modport slave (
    input  in_decode_reg_idx, in_rename_ce, in_rename_reg, in_rename_rob,
           in_commit_ce, in_commit_reg, in_commit_rob, in_commit_value, in_misbranch,
    output out_decode_value, out_decode_rob_tag, out_decode_busy, out_busy_cnt
  );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy bit and ROB tag, optional
// same-cycle commit forwarding to the read ports and a registered busy count.
module rename_regfile #(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = 32,
  parameter int ROB_TAG_W = 4,
  parameter int NUM_RD    = 2,
  parameter int BYPASS_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  rename_regfile_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  logic [DATA_W-1:0]    values [NUM_REGS];
  logic [ROB_TAG_W-1:0] tags   [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;
  logic [NUM_REGS-1:0]  busy_nxt;
  logic [CNT_W-1:0]     busy_cnt;
  logic [CNT_W-1:0]     cnt_nxt;

  logic [IDX_W-1:0] rd_idx [NUM_RD];
  logic [NUM_RD-1:0] rd_hit;
  logic commit_clr, ren_ok, cnt_inc, cnt_dec;

  // Read ports: registered state, optionally overridden by a matching commit.
  always_comb begin
    bus.out_decode_value   = '0;
    bus.out_decode_rob_tag = '0;
    bus.out_decode_busy    = '0;
    rd_hit                 = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_idx[p] = bus.in_decode_reg_idx[p*IDX_W +: IDX_W];
      rd_hit[p] = (BYPASS_EN != 0) && bus.in_commit_ce && (rd_idx[p] != '0) &&
                  (bus.in_commit_reg == rd_idx[p]) && busy[rd_idx[p]] &&
                  (tags[rd_idx[p]] == bus.in_commit_rob);
      if (rd_idx[p] != '0) begin
        bus.out_decode_value[p*DATA_W +: DATA_W]      = rd_hit[p] ? bus.in_commit_value
                                                                  : values[rd_idx[p]];
        bus.out_decode_rob_tag[p*ROB_TAG_W +: ROB_TAG_W] = tags[rd_idx[p]];
        bus.out_decode_busy[p]                        = busy[rd_idx[p]] && !rd_hit[p];
      end
    end
  end

  // Next busy vector and count; a same-reg rename overrides the commit clear.
  always_comb begin
    commit_clr = bus.in_commit_ce && (bus.in_commit_reg != '0) &&
                 busy[bus.in_commit_reg] && (tags[bus.in_commit_reg] == bus.in_commit_rob);
    ren_ok     = bus.in_rename_ce && (bus.in_rename_reg != '0);
    cnt_inc    = ren_ok && !busy[bus.in_rename_reg];
    cnt_dec    = commit_clr && !(ren_ok && (bus.in_rename_reg == bus.in_commit_reg));
    busy_nxt   = busy;
    if (commit_clr) busy_nxt[bus.in_commit_reg] = 1'b0;
    if (ren_ok)     busy_nxt[bus.in_rename_reg] = 1'b1;
    cnt_nxt    = busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    if (bus.in_misbranch) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        values[i] <= '0;
        tags[i]   <= '0;
      end
      busy     <= '0;
      busy_cnt <= '0;
    end else if (rdy) begin
      if (bus.in_commit_ce && (bus.in_commit_reg != '0))
        values[bus.in_commit_reg] <= bus.in_commit_value;
      if (bus.in_misbranch) begin
        for (int i = 0; i < NUM_REGS; i++) tags[i] <= '0;
      end else if (ren_ok) begin
        tags[bus.in_rename_reg] <= bus.in_rename_rob;
      end
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign bus.out_busy_cnt = busy_cnt;
endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: expected read-port and count values are
// queued as stimulus is applied and popped when the DUT outputs are sampled.
module tb_rename_regfile;
  localparam int NUM_REGS = 32, DATA_W = 32, ROB_TAG_W = 4, NUM_RD = 2;

  logic clk, rst, rdy;
  int   n_checks, n_errors;

  logic [63:0] exp_q [$];
  string       name_q [$];

  rename_regfile_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ROB_TAG_W(ROB_TAG_W),
                      .NUM_RD(NUM_RD)) bus ();

  rename_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ROB_TAG_W(ROB_TAG_W),
                   .NUM_RD(NUM_RD), .BYPASS_EN(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string n, input logic [63:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      chk(name_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic expect_port(input int p, input string n, input logic [31:0] v,
                             input logic b, input logic [3:0] t);
    push({n, "_val"}, 64'(v));
    push({n, "_busy"}, 64'(b));
    push({n, "_tag"}, 64'(t));
  endtask

  task automatic sample_port(input int p);
    pop_chk(64'(bus.out_decode_value[p*DATA_W +: DATA_W]));
    pop_chk(64'(bus.out_decode_busy[p]));
    pop_chk(64'(bus.out_decode_rob_tag[p*ROB_TAG_W +: ROB_TAG_W]));
  endtask

  task automatic check_cnt(input string n, input int c);
    push(n, 64'(c));
    pop_chk(64'(bus.out_busy_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idx(input int i0, input int i1);
    bus.in_decode_reg_idx = {5'(i1), 5'(i0)};
  endtask

  task automatic rename(input int r, input int t);
    bus.in_rename_ce  = 1'b1;
    bus.in_rename_reg = 5'(r);
    bus.in_rename_rob = 4'(t);
  endtask

  task automatic commit(input int r, input int t, input logic [31:0] v);
    bus.in_commit_ce    = 1'b1;
    bus.in_commit_reg   = 5'(r);
    bus.in_commit_rob   = 4'(t);
    bus.in_commit_value = v;
  endtask

  task automatic idle();
    bus.in_rename_ce = 1'b0;
    bus.in_commit_ce = 1'b0;
    bus.in_misbranch = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    rdy = 1'b1;
    bus.in_rename_reg = '0; bus.in_rename_rob = '0;
    bus.in_commit_reg = '0; bus.in_commit_rob = '0; bus.in_commit_value = '0;
    idle();
    set_idx(5, 0);
    #1;
    // 1: reset state
    expect_port(0, "rst_x5", 0, 0, 0); sample_port(0);
    expect_port(1, "rst_x0", 0, 0, 0); sample_port(1);
    check_cnt("rst_cnt", 0);
    tick(); tick();
    rst = 1'b1;

    // 2: rename, bypassed commit, then registered commit
    rename(3, 7); tick(); idle();
    set_idx(3, 0); #1;
    expect_port(0, "ren_x3", 0, 1, 7); sample_port(0);
    check_cnt("ren_cnt", 1);
    commit(3, 7, 32'hDEADBEEF); #1;
    expect_port(0, "byp_x3", 32'hDEADBEEF, 0, 7); sample_port(0);
    tick(); idle(); #1;
    expect_port(0, "cmt_x3", 32'hDEADBEEF, 0, 7); sample_port(0);
    check_cnt("cmt_cnt", 0);

    // 3: stale-tag commit keeps busy
    rename(4, 2); tick();
    rename(4, 5); tick(); idle();
    commit(4, 2, 32'd11); set_idx(4, 0); #1;
    expect_port(0, "stale_nobyp", 0, 1, 5); sample_port(0);
    tick(); idle(); #1;
    expect_port(0, "stale_x4", 11, 1, 5); sample_port(0);
    check_cnt("stale_cnt", 1);

    // 4: same-cycle commit and rename to one register
    rename(6, 1); tick(); idle(); #1;
    check_cnt("x6_cnt", 2);
    commit(6, 1, 32'h66); rename(6, 9); set_idx(4, 6); #1;
    expect_port(1, "same_byp", 32'h66, 0, 1); sample_port(1);
    tick(); idle(); #1;
    expect_port(1, "same_x6", 32'h66, 1, 9); sample_port(1);
    check_cnt("same_cnt", 2);

    // 5: misbranch beats rename; reg 0 ignores writes
    rename(1, 10); tick();
    rename(2, 11); tick();
    rename(7, 12); tick(); idle(); #1;
    check_cnt("five_cnt", 5);
    bus.in_misbranch = 1'b1; rename(8, 3); tick(); idle();
    set_idx(8, 4); #1;
    expect_port(0, "mis_x8", 0, 0, 0); sample_port(0);
    expect_port(1, "mis_x4", 11, 0, 0); sample_port(1);
    check_cnt("mis_cnt", 0);
    rename(0, 6); commit(0, 0, 32'd5); set_idx(0, 8); #1;
    expect_port(0, "x0_byp", 0, 0, 0); sample_port(0);
    tick(); idle(); #1;
    expect_port(0, "x0_after", 0, 0, 0); sample_port(0);
    check_cnt("x0_cnt", 0);

    // 6: rdy low freezes state, bypass still forwards
    rename(9, 4); tick(); idle();
    rdy = 1'b0;
    rename(9, 8); bus.in_misbranch = 1'b1; commit(9, 4, 32'h99); set_idx(9, 0); #1;
    expect_port(0, "frz_byp", 32'h99, 0, 4); sample_port(0);
    tick(); tick();
    bus.in_commit_ce = 1'b0; #1;
    expect_port(0, "frz_x9", 0, 1, 4); sample_port(0);
    check_cnt("frz_cnt", 1);
    idle(); rdy = 1'b1;
    rename(12, 2); tick(); idle();
    set_idx(9, 12); #1;
    check_cnt("pre_rst_cnt", 2);
    #2 rst = 1'b0;
    #1;
    expect_port(0, "arst_x9", 0, 0, 0); sample_port(0);
    expect_port(1, "arst_x12", 0, 0, 0); sample_port(1);
    check_cnt("arst_cnt", 0);

    if (exp_q.size() != 0) chk("scoreboard_left", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
